step_sequencer: RTL and testbench
=================================

# step_sequencer

Generates the 4-bit instruction timestep (T0..Tn) consumed directly by the binary-to-one-hot timestep decoder in the CPU control path. It counts steps while the CPU runs, restarts at T0 when the control unit signals end of instruction or when the last legal step is reached, and supports halt and an optional single-step debug mode. It also maintains a running count of completed instructions.

## Interface
- MAX_STEP, 9, last legal step value; legal range 1..9 so every output decodes to a non-zero one-hot.
- CNT_W, 8, width of completed-instruction counter.
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  pulse; leaves IDLE and begins sequencing at T0.
- stop  in  1  level; return to IDLE at the next instruction boundary.
- done  in  1  control unit: current step is the last of this instruction.
- halt  in  1  level; freeze current step.
- sstep_mode  in  1  level; single-step enable (macro-gated).
- step_req  in  1  single-step advance request (macro-gated).
- step_ack  out  1  one-cycle pulse; requested step now visible (macro-gated).
- step  out  4  current timestep, feeds the one-hot decoder.
- busy  out  1  high whenever state is not IDLE.
- instr_done  out  1  one-cycle pulse on each instruction boundary.
- instr_count  out  CNT_W  completed instructions, wraps modulo 2^CNT_W.

## Operation
- States: IDLE, RUN, HOLD.
- IDLE: step=0, busy=0; start -> RUN, step stays 0.
- RUN, per edge, priority order: halt -> HOLD (step unchanged); else boundary (done=1 or step==MAX_STEP) -> step=0, instr_done=1, instr_count+1, and -> IDLE if stop=1; else step+1.
- HOLD: step, instr_count frozen; done/start ignored; halt=0 -> RUN, increment resumes next edge (no step skipped or repeated).
- start while busy: ignored. stop alone never truncates an instruction.
- Single-step (RUN, sstep_mode=1): an edge advances (or takes boundary) only when step_req=1; otherwise step holds. halt still overrides.
- instr_count wraps from 2^CNT_W-1 to 0.
- step never exceeds MAX_STEP; out-of-range values are unreachable.

## Timing
- Reset: state=IDLE, step=0, busy=0, instr_done=0, step_ack=0, instr_count=0; async assert, sync deassert at use.
- Reset mid-instruction: immediate return to reset values; no instr_done.
- All outputs registered; input effect visible one edge later.
- start at edge k: busy=1, step=0 after k; step=1 after k+1.
- instr_done asserted in the same cycle step returns to 0.
- halt and boundary in same cycle: halt wins, boundary taken after release.
- step_ack high exactly in the cycle the advanced step is first visible; step_req held high advances every cycle.

## Configuration
- STEP_SEQ_SSTEP_EN defined: sstep_mode, step_req, step_ack present, behaviour as above.
- Undefined: ports absent, sequencer always free-runs in RUN.

## Structure
- Shared package step_seq_pkg: state enum (IDLE, RUN, HOLD), STEP_W=4, default MAX_STEP=9.
- Single flat module; no sub-module is natural. Decoder instantiated by parent, not here.

## Test plan
- Reset then start, done never asserted: step 0,1,..,9,0 with instr_done at the 9->0 cycle; instr_count=1.
- done asserted at step=3: next step=0, instr_done pulse, instr_count increments; step 4 never appears.
- halt at step=5 for 4 cycles: step stays 5, busy=1; after release step=6 next edge.
- stop held during run, done at step=2: step=0, busy=0, state IDLE; further start restarts at 0.
- With STEP_SEQ_SSTEP_EN, sstep_mode=1, step_req pulses every 3 cycles: step advances once per pulse, step_ack aligned with each new value.
- resetn low at step=7 with CNT_W=2 after 3 instructions: all outputs zero; run 5 instructions -> instr_count=1 (wrap).

Source files
------------

// File: rtl/step_seq_pkg.sv
// Shared types and constants for the instruction timestep sequencer.
package step_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int STEP_W       = 4;
  localparam int MAX_STEP_DEF = 9;

endpackage

// File: rtl/step_sequencer.sv
// Instruction timestep sequencer: emits T0..MAX_STEP for the one-hot decoder and counts completed instructions.
// Optional single-step debug ports are enabled by defining STEP_SEQ_SSTEP_EN.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int MAX_STEP = MAX_STEP_DEF,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              done,
  input  logic              halt,
`ifdef STEP_SEQ_SSTEP_EN
  input  logic              sstep_mode,
  input  logic              step_req,
  output logic              step_ack,
`endif
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              instr_done,
  output logic [CNT_W-1:0]  instr_count
);

  state_t state;
  logic   adv;
  logic   boundary;

`ifdef STEP_SEQ_SSTEP_EN
  assign adv = !sstep_mode || step_req;
`else
  assign adv = 1'b1;
`endif

  // done from the control unit or the last legal step both close the instruction
  assign boundary = done || (step == STEP_W'(MAX_STEP));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      step        <= '0;
      busy        <= 1'b0;
      instr_done  <= 1'b0;
      instr_count <= '0;
`ifdef STEP_SEQ_SSTEP_EN
      step_ack    <= 1'b0;
`endif
    end else begin
      instr_done <= 1'b0;
`ifdef STEP_SEQ_SSTEP_EN
      step_ack   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            step  <= '0;
          end
        end
        // Releasing HOLD behaves as a normal RUN edge so the held step is neither skipped nor repeated
        RUN, HOLD: begin
          if (halt) begin
            state <= HOLD;
          end else begin
            state <= RUN;
            if (adv) begin
`ifdef STEP_SEQ_SSTEP_EN
              step_ack <= sstep_mode;
`endif
              if (boundary) begin
                step        <= '0;
                instr_done  <= 1'b1;
                instr_count <= instr_count + CNT_W'(1);
                if (stop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                step <= step + STEP_W'(1);
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          step  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed-vector bench for step_sequencer (CNT_W=2 so counter wrap is reachable quickly).
module tb_step_sequencer;
  import step_seq_pkg::*;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0, stop = 1'b0, done = 1'b0, halt = 1'b0;
`ifdef STEP_SEQ_SSTEP_EN
  logic          sstep_mode = 1'b0, step_req = 1'b0, step_ack;
`endif
  logic [3:0]    step;
  logic          busy, instr_done;
  logic [CW-1:0] instr_count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic st, sp, dn, hl;
    int   s;
    logic b, id;
    int   c;
  } vec_t;

  vec_t tbl[$];

  step_sequencer #(.MAX_STEP(9), .CNT_W(CW)) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .stop(stop),
    .done(done),
    .halt(halt),
`ifdef STEP_SEQ_SSTEP_EN
    .sstep_mode(sstep_mode),
    .step_req(step_req),
    .step_ack(step_ack),
`endif
    .step(step),
    .busy(busy),
    .instr_done(instr_done),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic add(input logic st, sp, dn, hl, input int s, input logic b, id, input int c);
    vec_t v;
    v.st = st; v.sp = sp; v.dn = dn; v.hl = hl;
    v.s = s; v.b = b; v.id = id; v.c = c;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int s, input logic b, id, input int c, input logic ack);
    logic ok;
    logic act_ack;
`ifdef STEP_SEQ_SSTEP_EN
    act_ack = step_ack;
`else
    act_ack = 1'b0;
`endif
    ok = (step == 4'(s)) && (busy == b) && (instr_done == id) &&
         (instr_count == CW'(c)) && (act_ack == ack);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got step=%0d busy=%b idone=%b cnt=%0d ack=%b, want step=%0d busy=%b idone=%b cnt=%0d ack=%b",
               nm, step, busy, instr_done, instr_count, act_ack, s, b, id, CW'(c), ack);
    end
  endtask

  task automatic cyc(input logic st, sp, dn, hl, input int s, input logic b, id, input int c,
                     input logic ack, input string nm);
    @(negedge clk);
    start = st; stop = sp; done = dn; halt = hl;
    @(posedge clk);
    #1;
    chk(nm, s, b, id, c, ack);
  endtask

  initial begin
    // Free-run one instruction to the last legal step
    add(1,0,0,0, 0,1,0,0);
    for (int s = 1; s <= 9; s++) add(0,0,0,0, s,1,0,0);
    add(0,0,0,0, 0,1,1,1);
    // done at step 3 ends the instruction early
    for (int s = 1; s <= 3; s++) add(0,0,0,0, s,1,0,1);
    add(0,0,1,0, 0,1,1,2);
    add(0,0,0,0, 1,1,0,2);
    // halt at step 5 for four cycles
    for (int s = 2; s <= 5; s++) add(0,0,0,0, s,1,0,2);
    for (int k = 0; k < 4; k++) add(0,0,0,1, 5,1,0,2);
    for (int s = 6; s <= 9; s++) add(0,0,0,0, s,1,0,2);
    add(0,0,0,0, 0,1,1,3);
    // stop held, done at step 2; counter wraps 3 -> 0
    add(0,1,0,0, 1,1,0,3);
    add(0,1,0,0, 2,1,0,3);
    add(0,1,1,0, 0,0,1,0);
    add(0,0,0,0, 0,0,0,0);
    add(0,0,1,0, 0,0,0,0);
    add(1,0,0,0, 0,1,0,0);
    add(0,0,0,0, 1,1,0,0);
    add(1,0,0,0, 2,1,0,0);
    add(0,1,0,0, 3,1,0,0);
    // halt beats a simultaneous done; boundary taken on release
    add(0,0,1,1, 3,1,0,0);
    add(0,0,1,0, 0,1,1,1);

    repeat (2) @(negedge clk);
    chk("reset_state", 0, 1'b0, 1'b0, 0, 1'b0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", 0, 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].st, tbl[i].sp, tbl[i].dn, tbl[i].hl, tbl[i].s, tbl[i].b, tbl[i].id, tbl[i].c,
          1'b0, $sformatf("tbl[%0d]", i));

    // Asynchronous reset in the middle of an instruction at step 7
    for (int s = 1; s <= 7; s++) cyc(0,0,0,0, s,1'b1,1'b0,1, 1'b0, "pre_reset_run");
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("async_reset_mid", 0, 1'b0, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    chk("reset_held", 0, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    // Five one-step instructions wrap the 2-bit counter to 1
    cyc(1,0,0,0, 0,1'b1,1'b0,0, 1'b0, "restart");
    for (int k = 1; k <= 5; k++) cyc(0,0,1,0, 0,1'b1,1'b1,k % 4, 1'b0, $sformatf("wrap_instr%0d", k));
    cyc(0,0,0,0, 1,1'b1,1'b0,1, 1'b0, "post_wrap");

`ifdef STEP_SEQ_SSTEP_EN
    // Single-step: one request every third cycle advances exactly once
    begin
      int cur;
      cur = 1;
      sstep_mode = 1'b1;
      for (int i = 0; i < 8; i++) begin
        step_req = 1'b0;
        cyc(0,0,0,0, cur,1'b1,1'b0,1, 1'b0, "sstep_hold");
        cyc(0,0,0,0, cur,1'b1,1'b0,1, 1'b0, "sstep_hold");
        step_req = 1'b1;
        cur++;
        cyc(0,0,0,0, cur,1'b1,1'b0,1, 1'b1, "sstep_adv");
      end
      cyc(0,0,0,0, 0,1'b1,1'b1,2, 1'b1, "sstep_boundary");
      cyc(0,0,0,0, 1,1'b1,1'b0,2, 1'b1, "sstep_req_held");
      cyc(0,0,0,1, 1,1'b1,1'b0,2, 1'b0, "sstep_halt_wins");
      step_req = 1'b0;
      sstep_mode = 1'b0;
      cyc(0,0,0,0, 2,1'b1,1'b0,2, 1'b0, "sstep_off");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
